// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider.
// - o_clk has a 50% duty cycle for both even and odd divisors.
// - o_tick is a one-clk strobe, issued once per output period.
// - A divisor requested with load takes effect only at a period boundary.
// - Divisor 1 passes clk straight through to o_clk.
// Optional debug outputs cnt_o / div_act_o are built when the macro
// CLKDIV_CNT_OUT_EN is defined; the divider behaves the same either way.
module clk_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic             o_clk,
    output logic             o_tick,
    output logic             busy
`ifdef CLKDIV_CNT_OUT_EN
    ,
    output logic [WIDTH-1:0] cnt_o,
    output logic [WIDTH-1:0] div_act_o
`endif
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_DIV = (DEFAULT_DIV == 0) ? ONE : WIDTH'(DEFAULT_DIV);

    // Map a requested divisor of zero onto one.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d == {WIDTH{1'b0}}) ? ONE : d;
    endfunction

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_valid;
    logic             r_clk_p;
    logic             r_clk_n;
    logic             r_tick;

    logic             w_last;
    logic             w_boundary;
    logic             w_bypass;
    logic [WIDTH-1:0] w_half;
    logic             w_clk_sel;

    // r_div_act is never zero, so subtracting one cannot underflow.
    assign w_last     = (r_cnt == (r_div_act - ONE));
    assign w_boundary = (~en) | w_last;
    assign w_bypass   = (r_div_act == ONE);
    assign w_half     = r_div_act >> 1;

    // Period counter, high-phase register and tick strobe; all clear while paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= {WIDTH{1'b0}};
            r_clk_p <= 1'b0;
            r_tick  <= 1'b0;
        end else if (en) begin
            r_cnt   <= w_last ? {WIDTH{1'b0}} : (r_cnt + ONE);
            r_clk_p <= (r_cnt < w_half);
            r_tick  <= (r_cnt == {WIDTH{1'b0}});
        end else begin
            r_cnt   <= {WIDTH{1'b0}};
            r_clk_p <= 1'b0;
            r_tick  <= 1'b0;
        end
    end

    // Pending-divisor capture and application at a period boundary.
    // - When load and a boundary coincide, the old pending value is applied first.
    // - The newly captured value then stays pending for the next boundary.
    // - The counter is already zero after any boundary, so it needs no extra clear here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_act    <= RST_DIV;
            r_pend       <= {WIDTH{1'b0}};
            r_pend_valid <= 1'b0;
        end else begin
            if (w_boundary && r_pend_valid) begin
                r_div_act    <= clamp_div(r_pend);
                r_pend_valid <= 1'b0;
            end
            if (load) begin
                r_pend       <= div_val;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Half-cycle delayed copy of the high phase, used to stretch odd divisors by half a clk.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_n <= 1'b0;
        end else begin
            r_clk_n <= r_clk_p;
        end
    end

    // Output clock select: straight-through, odd stretch, or plain even phase.
    always_comb begin
        w_clk_sel = 1'b0;
        if (w_bypass) begin
            w_clk_sel = clk;
        end else if (r_div_act[0]) begin
            w_clk_sel = r_clk_p | r_clk_n;
        end else begin
            w_clk_sel = r_clk_p;
        end
    end

    assign o_clk  = w_clk_sel;
    assign o_tick = w_bypass ? en : r_tick;
    assign busy   = r_pend_valid;

`ifdef CLKDIV_CNT_OUT_EN
    assign cnt_o     = r_cnt;
    assign div_act_o = r_div_act;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog.
// - A fixed vector table covers reset, divide-by-6 and a reload to 5.
// - Hand sequences and random traffic are then checked against a behavioural model.
// - The model says o_clk is high for the first N half-cycles of each N-clk period.
module tb_clk_div_prog;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         load;
    logic [W-1:0] div_val;
    logic         o_clk;
    logic         o_tick;
    logic         busy;
`ifdef CLKDIV_CNT_OUT_EN
    logic [W-1:0] cnt_o;
    logic [W-1:0] div_act_o;
`endif

    clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .o_clk   (o_clk),
        .o_tick  (o_tick),
        .busy    (busy)
`ifdef CLKDIV_CNT_OUT_EN
        ,
        .cnt_o     (cnt_o),
        .div_act_o (div_act_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: active divisor, clk index within the period, pending divisor.
    int m_div;
    int m_pos;
    int m_pend;
    int m_pv;

    typedef struct {
        logic         e;
        logic         l;
        logic [W-1:0] v;
        logic         hi;
        logic         lo;
        logic         tick;
        logic         bsy;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_row(input int i, input logic l, input int v,
                           input logic hi, input logic lo, input logic tk, input logic bz);
        tbl[i] = '{1'b1, l, W'(v), hi, lo, tk, bz};
    endtask

    task automatic model_reset();
        m_div  = 6;
        m_pos  = 0;
        m_pend = 0;
        m_pv   = 0;
    endtask

    // Drive one clk of stimulus, advance the model and compare.
    // Entered and left at negedge+2.
    task automatic step(input logic e, input logic l, input int v);
        int   nd;
        bit   bnd;
        bit   apply;
        logic et;
        logic eh;
        logic el;
        bit   ch;
        bit   cl;
        en      = e;
        load    = l;
        div_val = W'(v);
        @(posedge clk);
        bnd   = !e || (m_pos == m_div - 1);
        apply = bnd && (m_pv != 0);
        nd    = apply ? ((m_pend == 0) ? 1 : m_pend) : m_div;
        et    = e && ((nd == 1) || (m_pos == 0));
        ch    = 1'b1;
        cl    = 1'b1;
        if (nd == 1) begin
            eh = 1'b1;
            el = 1'b0;
        end else if (nd != m_div) begin
            ch = 1'b0;
            cl = 1'b0;
            eh = 1'b0;
            el = 1'b0;
        end else if (!e) begin
            ch = 1'b0;
            eh = 1'b0;
            el = 1'b0;
        end else begin
            eh = (2 * m_pos < m_div);
            el = (2 * m_pos + 1 < m_div);
        end
        m_pos = e ? ((m_pos == m_div - 1) ? 0 : m_pos + 1) : 0;
        m_div = nd;
        if (apply) m_pv = 0;
        if (l) begin
            m_pend = v;
            m_pv   = 1;
        end
        #1;
        chk("tick", o_tick, et);
        chk("busy", busy, (m_pv != 0));
        if (ch) chk("oclk_hi", o_clk, eh);
        @(negedge clk);
        #1;
        if (cl) chk("oclk_lo", o_clk, el);
        #1;
    endtask

    // Short asynchronous reset pulse, taken away from any clock edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_oclk", o_clk, 1'b0);
        chk("rst_tick", o_tick, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        #1;
        model_reset();
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        div_val = '0;
        model_reset();

        // Divide by 6, then a load of 5 taken mid-period and applied at the wrap.
        set_row(0,  1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        set_row(1,  1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_row(2,  1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_row(3,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_row(4,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_row(5,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_row(6,  1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        set_row(7,  1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b1);
        set_row(8,  1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        set_row(9,  1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_row(10, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_row(11, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_row(12, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        set_row(13, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_row(14, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_row(15, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_row(16, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_row(17, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0);

        #2;
        chk("init_oclk", o_clk, 1'b0);
        chk("init_tick", o_tick, 1'b0);
        chk("init_busy", busy, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 18; i++) begin
            en      = tbl[i].e;
            load    = tbl[i].l;
            div_val = tbl[i].v;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_tick", i), o_tick, tbl[i].tick);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_hi", i), o_clk, tbl[i].hi);
            @(negedge clk);
            #1;
            chk($sformatf("tbl%0d_lo", i), o_clk, tbl[i].lo);
            #1;
        end

        // Load 0 then 1 (last wins, 0 would also mean 1): bypass, then back to 4.
        pulse_reset();
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 4);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0);

        // Pause for 10 clks mid-period at divide-by-6, then resume.
        pulse_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 0);

        // Two loads before one boundary: only the second one is applied.
        pulse_reset();
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 7);
        step(1'b1, 1'b1, 9);
        for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 0);

        // Load on the boundary clk itself: applied one period later.
        for (int i = 0; i < 12; i++) begin
            if (m_pos != m_div - 1) step(1'b1, 1'b0, 0);
        end
        step(1'b1, 1'b1, 3);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 0);

        // Odd divisor paused and resumed.
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0);

        // Reset mid-period with a divisor still pending.
        step(1'b1, 1'b1, 8);
        step(1'b1, 1'b0, 0);
        pulse_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 9)));
        end

        load = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable clock divider with 50% duty output for both even and odd divisors, plus a one-cycle tick strobe. It replaces the fixed-divisor dividers used to derive pixel, game-tick and debounce clocks in the VGA game designs. A new divisor is requested by a load pulse and is applied only at a period boundary, so the output never carries a runt pulse. The divider can be paused with an enable input.

Parameters:
WIDTH, 16, width of the divisor and the cycle counter
DEFAULT_DIV, 6, active divisor after reset; 0 is treated as 1

Ports:
clk  in  1  source clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; when low, the divider is held idle
load  in  1  one-clk pulse that captures div_val as the pending divisor
div_val  in  WIDTH  requested divisor N; 0 is treated as 1
o_clk  out  1  divided clock
o_tick  out  1  one-clk-wide strobe, once per output period
busy  out  1  high while a pending divisor has not yet been applied

Behaviour:
Interface: reset rst_n, asynchronous, active-low; clock clk.

Reset:
- cnt=0; div_act=DEFAULT_DIV (0 mapped to 1); pend_valid=0.
- clk_p=0, clk_n=0, o_tick=0, busy=0.
- o_clk=0, except when div_act==1 (bypass, see below).

Counter, on posedge with en=1:
- cnt <= (cnt==div_act-1) ? 0 : cnt+1.
- clk_p <= (cnt < div_act>>1), using the pre-update cnt.
- o_tick <= (cnt==0). It rises on the same edge as clk_p.

Half-cycle stretch, on negedge:
- clk_n <= clk_p.

Output select:
- div_act==1: o_clk=clk (combinational bypass) and o_tick=1 continuously while en=1.
- div_act odd and >1: o_clk = clk_p | clk_n. Duty is exactly 50%: high for N/2 source periods.
- div_act even: o_clk = clk_p.

First-period timing:
- The first enabled posedge after reset or after en rises drives clk_p=1 and o_tick=1.
- The output period is then div_act clk cycles.

Pause (en=0):
- At each posedge: cnt<=0, clk_p<=0, o_tick<=0. clk_n follows to 0 at the next negedge.
- o_clk is therefore low within one clk period.
- A pending divisor is applied on the first posedge with en=0.

Reload:
- A posedge with load=1 writes pend<=div_val and pend_valid<=1.
- A second load before the boundary overwrites pend (last write wins).
- Boundary = a posedge with en=1 and cnt==div_act-1, or any posedge with en=0.
- At a boundary with pend_valid=1: div_act<=max(pend,1), pend_valid<=0, cnt<=0.
- If load and a boundary coincide, the old pend (if valid) is applied. The newly captured value stays pending for the next boundary, with busy=1.
- busy = pend_valid.

Arithmetic:
- All comparisons are unsigned WIDTH-bit.
- div_act-1 is evaluated on div_act≥1, so there is no underflow.
- Max divisor is 2^WIDTH-1.

Reset mid-operation:
- Immediately returns all state to the reset values.
- Any pending divisor is discarded.

Optional Feature:
Macro: CLKDIV_CNT_OUT_EN.
- Defined: adds output ports cnt_o[WIDTH-1:0] (equal to cnt) and div_act_o[WIDTH-1:0] (equal to div_act), for debug and for phase-aligned consumers.
- Undefined: these ports and their logic are absent.
- Divider behaviour is identical in both cases.

Test Plan:
1. Reset, en=1, DEFAULT_DIV=6 -> o_clk high 3 / low 3 clk cycles; o_tick one clk wide every 6 clks, aligned with the o_clk rising edge.
2. load with div_val=5 mid-period -> busy=1 until the next cnt==5→0 wrap, then busy=0. After that, o_clk high 2.5 / low 2.5 clks (measured on both edges) and o_tick every 5 clks; the previous period is not truncated.
3. load div_val=0, then div_val=1 -> after the boundary, o_clk mirrors clk and o_tick stays at 1; loading 4 afterwards restores a 2/2 pattern.
4. Drop en for 10 clks mid-period with div=6 -> o_clk low within one clk, no ticks. On re-enable, the first posedge gives o_tick=1 and o_clk rises, followed by full 6-clk periods.
5. Two loads (7, then 9) before one boundary -> only 9 is applied. Separately, load coinciding with the boundary -> that value is applied at the following boundary.
6. Assert rst_n low mid-period, with pend valid, for 1 ns -> all outputs return to reset values, the divisor reverts to DEFAULT_DIV, and busy=0.
